// File: rtl/mux_nway_reg.sv
// Registered N-way multiplexer with a valid/ready handshake on every channel and on the output.
// Round-robin selection is built only when MUX_NWAY_RR_EN is defined; otherwise selection is fixed via sel.
module mux_nway_reg #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = ($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    rr_mode,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        grant
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] grant_q,     grant_d;
    logic             slot_free;
    logic             cand_found;
    logic [SEL_W-1:0] cand;
    logic             xfer;

    assign slot_free = !out_valid_q || out_ready;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        in_ready = '0;
        if (rst_n && cand_found && slot_free) begin
            in_ready[cand] = 1'b1;
        end
        xfer = |(in_valid & in_ready);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        grant_d     = grant_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(cand)*WIDTH +: WIDTH];
            grant_d     = cand;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: out_data is reset too, so a word discarded by reset is never visible afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            grant_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            grant_q     <= grant_d;
        end
    end

`ifdef MUX_NWAY_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] rr_cand;
    logic             rr_found;

    // Rotating-priority search: first valid channel at ptr_q, ptr_q+1, ... modulo NUM_IN.
    always_comb begin
        rr_found = 1'b0;
        rr_cand  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!rr_found && in_valid[(int'(ptr_q) + k) % NUM_IN]) begin
                rr_found = 1'b1;
                rr_cand  = SEL_W'((int'(ptr_q) + k) % NUM_IN);
            end
        end
    end

    always_comb begin
        cand       = sel;
        cand_found = (int'(sel) < NUM_IN);
        if (rr_mode) begin
            cand       = rr_cand;
            cand_found = rr_found;
        end
    end

    // The pointer only advances on round-robin transfers and survives fixed-mode periods.
    always_comb begin
        ptr_d = ptr_q;
        if (rr_mode && xfer) begin
            ptr_d = SEL_W'((int'(cand) + 1) % NUM_IN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_rr_mode;
    assign unused_rr_mode = rr_mode;

    assign cand       = sel;
    assign cand_found = (int'(sel) < NUM_IN);
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign grant     = grant_q;

endmodule
